gpu_issue_scheduler: RTL and testbench

- Round-robin scheduler that shares one basic_gpu execution unit among NUM_REQ instruction requesters (warps).
- Arbitrates, holds the selected instruction on the GPU's valid/ready interface for the whole operation, captures the result when the GPU returns to ready, and routes it back tagged with the requester id.
- A watchdog flags a GPU that never accepts or never completes.

---
 rtl/gpu_issue_scheduler.sv | 145 ++++++++++++++
 tb/tb_gpu_issue_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_issue_scheduler.sv
// Round-robin issue scheduler sharing one basic_gpu execution unit among NUM_REQ
// requesters, with a watchdog that aborts operations the GPU never accepts or completes.
module gpu_issue_scheduler #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_instr,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [31:0]            rsp_data,
  output logic [31:0]            gpu_instruction,
  output logic                   gpu_valid,
  input  logic                   gpu_ready,
  input  logic [31:0]            gpu_result,
  output logic                   timeout_err,
  output logic [CNT_W-1:0]       issue_count
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_DONE = 2'd2;

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_cur_id;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_gpu_valid;
  logic [31:0]      r_gpu_instr;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [31:0]      r_rsp_data;
  logic             r_timeout_err;
  logic [CNT_W-1:0] r_issue_count;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [31:0]        w_grant_instr;
  logic               w_xfer;
  logic               w_exit_normal;
  logic               w_abort;

  // Search starts just above the last winner so every requester gets a turn.
  always_comb begin
    w_grant       = '0;
    w_grant_id    = '0;
    w_grant_instr = '0;
    if (r_state == S_IDLE) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        automatic int idx = (int'(r_ptr) + k) % NUM_REQ;
        if ((w_grant == '0) && req_valid[idx]) begin
          w_grant[idx]  = 1'b1;
          w_grant_id    = ID_W'(idx);
          w_grant_instr = req_instr[32*idx +: 32];
        end
      end
    end
  end

  assign w_xfer        = |(w_grant & req_valid);
  assign w_exit_normal = ((r_state == S_ISSUE) && !gpu_ready) ||
                         ((r_state == S_WAIT_DONE) && gpu_ready);
  // A normal exit landing on the last watchdog cycle takes precedence over the abort.
  assign w_abort       = (r_state != S_IDLE) && !w_exit_normal && (r_wd_cnt == WD_LAST);

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_ptr         <= PTR_RST;
      r_cur_id      <= '0;
      r_wd_cnt      <= '0;
      r_gpu_valid   <= 1'b0;
      r_gpu_instr   <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_data    <= '0;
      r_timeout_err <= 1'b0;
      r_issue_count <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state != S_IDLE) r_wd_cnt <= r_wd_cnt + 1'b1;

      if (w_abort) begin
        r_timeout_err <= 1'b1;
        r_gpu_valid   <= 1'b0;
        r_rsp_valid   <= 1'b1;
        r_rsp_data    <= '0;
        r_rsp_id      <= r_cur_id;
        r_issue_count <= r_issue_count + 1'b1;
        r_state       <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_xfer) begin
              r_gpu_instr <= w_grant_instr;
              r_cur_id    <= w_grant_id;
              r_ptr       <= w_grant_id;
              r_gpu_valid <= 1'b1;
              r_wd_cnt    <= '0;
              r_state     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            // The GPU signals acceptance by dropping ready.
            if (!gpu_ready) begin
              r_gpu_valid <= 1'b0;
              r_state     <= S_WAIT_DONE;
            end
          end
          S_WAIT_DONE: begin
            if (gpu_ready) begin
              r_rsp_valid   <= 1'b1;
              r_rsp_data    <= gpu_result;
              r_rsp_id      <= r_cur_id;
              r_issue_count <= r_issue_count + 1'b1;
              r_state       <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign req_grant       = w_grant;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_id          = r_rsp_id;
  assign rsp_data        = r_rsp_data;
  assign gpu_instruction = r_gpu_instr;
  assign gpu_valid       = r_gpu_valid;
  assign timeout_err     = r_timeout_err;
  assign issue_count     = r_issue_count;

endmodule

// File: tb/tb_gpu_issue_scheduler.sv
// Self-checking bench for gpu_issue_scheduler: table-driven arbitration vectors, a
// behavioural GPU stub with adjustable latency, and a response scoreboard.
module tb_gpu_issue_scheduler;

  localparam int          NREQ      = 4;
  localparam int          TO_CYC    = 8;
  localparam logic [31:0] ADD_INSTR = 32'h0188_E000;
  localparam logic [31:0] GPU_R1    = 32'd5;
  localparam logic [31:0] GPU_R2    = 32'd7;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_instr;
  logic [NREQ-1:0]     req_grant;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [31:0]         rsp_data;
  logic [31:0]         gpu_instruction;
  logic                gpu_valid;
  logic                gpu_ready;
  logic [31:0]         gpu_result;
  logic                timeout_err;
  logic [15:0]         issue_count;

  gpu_issue_scheduler #(
    .NUM_REQ(NREQ), .ID_W(2), .TIMEOUT_CYCLES(TO_CYC), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_instr(req_instr), .req_grant(req_grant),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .gpu_instruction(gpu_instruction), .gpu_valid(gpu_valid),
    .gpu_ready(gpu_ready), .gpu_result(gpu_result),
    .timeout_err(timeout_err), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // GPU stub: only the test-plan ADD is decoded; anything else maps to a fixed transform.
  function automatic logic [31:0] gpu_fn(input logic [31:0] ins);
    if (ins == ADD_INSTR) return GPU_R1 + GPU_R2;
    return ins ^ 32'hA5A5_5A5A;
  endfunction

  // Accept on valid&ready, sample the instruction one cycle later, return ready after
  // gpu_lat busy cycles. gpu_stuck models a GPU that never accepts.
  int          gpu_lat   = 3;
  bit          gpu_stuck = 1'b0;
  int          gpu_busy  = 0;
  logic [31:0] gpu_sampled;

  always @(posedge clk) begin
    if (rst) begin
      gpu_ready   <= 1'b1;
      gpu_result  <= '0;
      gpu_busy    <= 0;
      gpu_sampled <= '0;
    end else if (gpu_stuck) begin
      gpu_ready <= 1'b1;
    end else if (gpu_ready && gpu_valid) begin
      gpu_ready <= 1'b0;
      gpu_busy  <= 1;
    end else if (!gpu_ready) begin
      if (gpu_busy == 1) gpu_sampled <= gpu_instruction;
      if (gpu_busy == gpu_lat) begin
        gpu_ready  <= 1'b1;
        gpu_result <= gpu_fn(gpu_sampled);
      end
      gpu_busy <= gpu_busy + 1;
    end
  end

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          cyc;
    bit          chk_acc;
  } exp_t;

  exp_t        sb[$];
  bit          op_active = 1'b0;
  logic [31:0] exp_instr;
  int          hold_bad;
  int          acc_cnt;

  always @(negedge clk) begin
    if (op_active) begin
      if (gpu_instruction !== exp_instr) hold_bad++;
      if (gpu_valid && gpu_ready) acc_cnt++;
    end
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp id=%0d data=0x%0h, expected none (cycle %0d)",
                 rsp_id, rsp_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_id", rsp_id, e.id);
        check("rsp_data", rsp_data, e.data);
        check("rsp_cycle", cyc, e.cyc);
        check("instr_hold", hold_bad, 0);
        if (e.chk_acc) check("accept_once", acc_cnt, 1);
        op_active = 1'b0;
      end
    end
  end

  typedef struct {
    logic [3:0] valid;
    logic [3:0] grant;
    int         lat;
    bit         stuck;
    bit         abort;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] instr_arr[NREQ];
  int          exp_count = 0;
  bit          exp_terr  = 1'b0;

  task automatic run_op(input vec_t v);
    int gidx = -1;
    for (int i = 0; i < NREQ; i++) if (v.grant[i]) gidx = i;
    @(negedge clk);
    gpu_lat   = v.lat;
    gpu_stuck = v.stuck;
    for (int i = 0; i < NREQ; i++) req_instr[32*i +: 32] = instr_arr[i];
    req_valid = v.valid;
    #1;
    check("grant", req_grant, v.grant);
    if (gidx >= 0) begin
      exp_t e;
      e.id      = 2'(gidx);
      e.data    = v.abort ? 32'd0 : gpu_fn(instr_arr[gidx]);
      e.cyc     = v.abort ? cyc + 1 + TO_CYC : cyc + 3 + v.lat;
      e.chk_acc = !v.stuck;
      sb.push_back(e);
      exp_count++;
      if (v.abort) exp_terr = 1'b1;
    end
    @(posedge clk);
    #1;
    if (gidx < 0) begin
      req_valid = '0;
      return;
    end
    hold_bad  = 0;
    acc_cnt   = 0;
    exp_instr = instr_arr[gidx];
    op_active = 1'b1;
    req_valid = v.valid & ~v.grant;
    @(negedge clk);
    check("grant_busy", req_grant, 4'b0000);
    req_valid = '0;
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(posedge clk);
      #2;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL rsp_wait: got no response within 40 cycles, expected id %0d", gidx);
      sb.delete();
      op_active = 1'b0;
    end
    check("issue_count", issue_count, 64'(exp_count));
    check("timeout_err", timeout_err, 64'(exp_terr));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_count = 0;
    exp_terr  = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_gpu_valid", gpu_valid, 0);
    check("rst_gpu_instr", gpu_instruction, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_timeout_err", timeout_err, 0);
    check("rst_issue_count", issue_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected end of test");
    $fatal(1, "bench timed out");
  end

  initial begin
    int seen;
    rst       = 1'b1;
    req_valid = '0;
    req_instr = '0;
    for (int i = 0; i < NREQ; i++) instr_arr[i] = 32'h3C00_0000 | 32'(i);
    do_reset();

    // Reset state: outputs cleared, requester 0 first in line.
    @(negedge clk);
    check_reset_outputs();
    req_valid = 4'b1111;
    #1;
    check("rst_priority", req_grant, 4'b0001);
    req_valid = 4'b0000;
    #1;
    check("grant_none", req_grant, 4'b0000);

    // Single ADD r3,r1,r2 from requester 2.
    instr_arr[2] = ADD_INSTR;
    run_op('{4'b0100, 4'b0100, 3, 1'b0, 1'b0});
    check("add_result_seen", dut.rsp_data, 32'd12);

    do_reset();
    for (int v = 0; v < 8; v++) vecs.push_back('{4'b1111, 4'(1 << (v % 4)), 3, 1'b0, 1'b0});
    vecs.push_back('{4'b1010, 4'b0010, 3, 1'b0, 1'b0});
    vecs.push_back('{4'b1010, 4'b1000, 3, 1'b0, 1'b0});
    vecs.push_back('{4'b0110, 4'b0010, 3, 1'b0, 1'b0});
    vecs.push_back('{4'b0101, 4'b0100, 3, 1'b0, 1'b0});
    vecs.push_back('{4'b0000, 4'b0000, 3, 1'b0, 1'b0});
    vecs.push_back('{4'b0001, 4'b0001, 3, 1'b0, 1'b0});
    vecs.push_back('{4'b1111, 4'b0010, 6, 1'b0, 1'b0});  // completes on the last watchdog cycle
    vecs.push_back('{4'b1111, 4'b0100, 7, 1'b0, 1'b1});  // one cycle too slow: abort in WAIT_DONE
    vecs.push_back('{4'b1000, 4'b1000, 3, 1'b1, 1'b1});  // never accepted: abort in ISSUE
    vecs.push_back('{4'b0001, 4'b0001, 3, 1'b0, 1'b0});  // still served after a timeout
    for (int v = 0; v < vecs.size(); v++) begin
      for (int i = 0; i < NREQ; i++) instr_arr[i] = 32'h3C00_0000 | (32'(v) << 8) | 32'(i);
      run_op(vecs[v]);
    end

    // Reset while in WAIT_DONE abandons the operation.
    @(negedge clk);
    req_instr[31:0] = 32'h7777_0000;
    req_valid = 4'b0001;
    #1;
    check("pre_rst_grant", req_grant, 4'b0001);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("in_wait_done", {gpu_valid, gpu_ready}, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_count = 0;
    exp_terr  = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_rsp_after_rst", seen, 0);
    for (int i = 0; i < NREQ; i++) instr_arr[i] = 32'h5A00_0000 | 32'(i);
    run_op('{4'b1111, 4'b0001, 3, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
